// File: rtl/reg_bank_param_if.sv
// Bus between the KGP-RISC control/datapath and reg_bank_param: write port,
// two read ports, soft clear request and status/debug outputs.
interface reg_bank_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clr;
    logic              RgW;
    logic [ADDR_W-1:0] wrA;
    logic [DATA_W-1:0] wrD;
    logic [ADDR_W-1:0] rdA;
    logic [ADDR_W-1:0] rdB;
    logic [DATA_W-1:0] rdDA;
    logic [DATA_W-1:0] rdDB;
    logic [DATA_W-1:0] rout;
    logic              ready;
    logic              addr_err;

    modport master (
        output clr, RgW, wrA, wrD, rdA, rdB,
        input  rdDA, rdDB, rout, ready, addr_err
    );

    modport slave (
        input  clr, RgW, wrA, wrD, rdA, rdB,
        output rdDA, rdDB, rout, ready, addr_err
    );
endinterface

// File: rtl/reg_bank_param.sv
// Parametrised register bank: one write port, two registered read ports, debug tap,
// sequential clear sweep and sticky range error. RF_BYPASS_EN selects write-first reads.
module reg_bank_param #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int DEBUG_REG = 7
) (
    input  logic            clock,
    input  logic            rst,
    reg_bank_param_if.slave bus
);
    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_a_q, rd_a_d;
    logic [DATA_W-1:0] rd_b_q, rd_b_d;
    logic              addr_err_q, addr_err_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    logic              wr_in, rd_a_in, rd_b_in;
    logic              user_wr;
    logic              we;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;

    // A bank that fills the whole address space can never see a bad address.
    if (NUM_REGS >= (2 ** ADDR_W)) begin : g_full_range
        assign wr_in   = 1'b1;
        assign rd_a_in = 1'b1;
        assign rd_b_in = 1'b1;
    end else begin : g_part_range
        assign wr_in   = (bus.wrA <= LAST_IDX);
        assign rd_a_in = (bus.rdA <= LAST_IDX);
        assign rd_b_in = (bus.rdB <= LAST_IDX);
    end

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_a_d     = '0;
        rd_b_d     = '0;
        addr_err_d = addr_err_q;
        user_wr    = 1'b0;
        we         = 1'b0;
        we_addr    = ptr_q;
        we_data    = '0;

        unique case (state_q)
            ST_CLEAR: begin
                we = 1'b1;
                if (bus.clr) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_RUN: begin
                user_wr = bus.RgW && wr_in && !bus.clr;
                we      = user_wr;
                we_addr = bus.wrA;
                we_data = bus.wrD;
                rd_a_d  = rd_a_in ? regs_q[bus.rdA] : '0;
                rd_b_d  = rd_b_in ? regs_q[bus.rdB] : '0;
`ifdef RF_BYPASS_EN
                if (user_wr && (bus.rdA == bus.wrA)) rd_a_d = bus.wrD;
                if (user_wr && (bus.rdB == bus.wrA)) rd_b_d = bus.wrD;
`endif
                if ((bus.RgW && !wr_in) || !rd_a_in || !rd_b_in) addr_err_d = 1'b1;
                // Entering CLEAR wins over a same-cycle range error.
                if (bus.clr) begin
                    state_d    = ST_CLEAR;
                    ptr_d      = '0;
                    addr_err_d = 1'b0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLEAR;
            ptr_q      <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_a_q     <= rd_a_d;
            rd_b_q     <= rd_b_d;
            addr_err_q <= addr_err_d;
        end
    end

    // NOTE: the array has no reset; the clear sweep zeroes it, so it can map onto plain storage.
    always_ff @(posedge clock) begin
        if (we) regs_q[we_addr] <= we_data;
    end

    assign bus.ready    = (state_q == ST_RUN);
    assign bus.rdDA     = rd_a_q;
    assign bus.rdDB     = rd_b_q;
    assign bus.addr_err = addr_err_q;
    assign bus.rout     = (state_q == ST_RUN) ? regs_q[DEBUG_REG] : '0;
endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param (NUM_REGS=24 so out-of-range addresses exist).
// Expected values are queued by the driver with the edge they are due after.
module tb_reg_bank_param;
    localparam int DATA_W    = 32;
    localparam int NUM_REGS  = 24;
    localparam int ADDR_W    = 5;
    localparam int DEBUG_REG = 7;

`ifdef RF_BYPASS_EN
    localparam logic [DATA_W-1:0] SAME_CYCLE_EXP = 32'h22;
`else
    localparam logic [DATA_W-1:0] SAME_CYCLE_EXP = 32'h11;
`endif

    typedef enum {K_RDA, K_RDB, K_READY, K_ROUT, K_ERR} kind_e;
    typedef struct {
        int                due;
        kind_e             kind;
        logic [DATA_W-1:0] exp;
        string             name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   edge_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    reg_bank_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_bank_param #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .DEBUG_REG(DEBUG_REG)
    ) dut (
        .clock(clk),
        .rst  (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic logic [DATA_W-1:0] sample(input kind_e k);
        case (k)
            K_RDA:   return bus.rdDA;
            K_RDB:   return bus.rdDB;
            K_READY: return DATA_W'(bus.ready);
            K_ROUT:  return bus.rout;
            default: return DATA_W'(bus.addr_err);
        endcase
    endfunction

    // Keeps the queue ordered by due edge so the monitor only ever looks at the head.
    function automatic void expect_at(input int due, input kind_e k,
                                      input logic [DATA_W-1:0] v, input string name);
        exp_t e;
        int   i;
        e.due  = due;
        e.kind = k;
        e.exp  = v;
        e.name = name;
        i = exp_q.size();
        while (i > 0 && exp_q[i-1].due > due) i--;
        exp_q.insert(i, e);
    endfunction

    function automatic void expect_next(input kind_e k, input logic [DATA_W-1:0] v,
                                        input string name);
        expect_at(edge_cnt + 1, k, v, name);
    endfunction

    // Monitor: compares every entry whose edge has occurred, half a cycle after that edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
                e = exp_q.pop_front();
                check(e.name, sample(e.kind), e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 100000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb, input logic clr);
        bus.RgW = we;
        bus.wrA = wa;
        bus.wrD = wd;
        bus.rdA = ra;
        bus.rdB = rb;
        bus.clr = clr;
    endtask

    // Queues the ready profile of a full sweep starting after edge 'start'.
    task automatic expect_sweep(input int start, input string name);
        for (int k = 1; k < NUM_REGS; k++) expect_at(start + k, K_READY, '0, name);
        expect_at(start + NUM_REGS, K_READY, 32'd1, name);
    endtask

    initial begin
        int c;
        drive(0, 0, 0, 0, 0, 0);

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("por ready", DATA_W'(bus.ready), '0);
        check("por rdDA", bus.rdDA, '0);
        check("por rdDB", bus.rdDB, '0);
        check("por addr_err", DATA_W'(bus.addr_err), '0);
        check("por rout", bus.rout, '0);
        repeat (2) step();

        // Reset sweep and all-zero contents.
        rst_n = 1'b1;
        expect_sweep(edge_cnt, "reset sweep ready");
        expect_at(edge_cnt + NUM_REGS, K_ROUT, '0, "rout after sweep");
        repeat (NUM_REGS) step();
        for (int i = 0; i < NUM_REGS; i++) begin
            drive(0, 0, 0, ADDR_W'(i), ADDR_W'(NUM_REGS - 1 - i), 0);
            expect_next(K_RDA, '0, "swept rdA");
            expect_next(K_RDB, '0, "swept rdB");
            step();
        end
        expect_at(edge_cnt, K_ERR, '0, "in-range reads no addr_err");

        // Write then read on both ports.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        drive(0, 0, 0, 5, 5, 0);
        expect_next(K_RDA, 32'hDEADBEEF, "r5 rdA");
        expect_next(K_RDB, 32'hDEADBEEF, "r5 rdB");
        step();

        // Debug tap follows r7 one edge after the write.
        drive(1, 7, 32'h1234, 0, 0, 0);
        expect_at(edge_cnt, K_ROUT, '0, "rout before write");
        expect_next(K_ROUT, 32'h1234, "rout after write");
        step();

        // Same-cycle read/write of r3.
        drive(1, 3, 32'h11, 0, 0, 0);
        step();
        drive(1, 3, 32'h22, 3, 3, 0);
        expect_next(K_RDA, SAME_CYCLE_EXP, "same-cycle rdA");
        expect_next(K_RDB, SAME_CYCLE_EXP, "same-cycle rdB");
        step();
        drive(0, 0, 0, 3, 0, 0);
        expect_next(K_RDA, 32'h22, "r3 after write");
        step();

        // Highest legal index works and raises no error.
        drive(1, 23, 32'h5A5A, 0, 0, 0);
        step();
        drive(0, 0, 0, 23, 23, 0);
        expect_next(K_RDA, 32'h5A5A, "r23 rdA");
        expect_next(K_ERR, '0, "r23 no addr_err");
        step();

        // Out-of-range write and read.
        drive(1, 30, 32'hFF, 0, 0, 0);
        expect_next(K_ERR, 32'd1, "bad write sets addr_err");
        step();
        drive(0, 0, 0, 5, 6, 0);
        expect_next(K_RDA, 32'hDEADBEEF, "r5 kept");
        expect_next(K_RDB, '0, "r6 kept");
        step();
        drive(0, 0, 0, 7, 23, 0);
        expect_next(K_RDA, 32'h1234, "r7 kept");
        expect_next(K_RDB, 32'h5A5A, "r23 kept");
        expect_next(K_ERR, 32'd1, "addr_err sticky");
        step();
        drive(0, 0, 0, 28, 3, 0);
        expect_next(K_RDA, '0, "bad read returns 0");
        expect_next(K_RDB, 32'h22, "r3 kept");
        expect_next(K_ERR, 32'd1, "addr_err still set");
        step();

        // Soft clear with a dropped same-cycle write.
        drive(1, 1, 32'hAA, 0, 0, 0);
        step();
        drive(1, 2, 32'hBB, 0, 0, 1);
        c = edge_cnt;
        expect_sweep(c + 1, "soft clear ready");
        expect_at(c, K_READY, 32'd1, "ready before clr");
        expect_at(c + 1, K_READY, '0, "ready falls on clr");
        expect_at(c + 1, K_ERR, '0, "clr clears addr_err");
        expect_at(c + 1, K_ROUT, '0, "rout forced 0 in clear");
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (NUM_REGS) step();
        drive(0, 0, 0, 1, 2, 0);
        expect_next(K_RDA, '0, "r1 cleared");
        expect_next(K_RDB, '0, "r2 cleared");
        expect_next(K_ERR, '0, "addr_err after clear");
        expect_next(K_ROUT, '0, "r7 cleared");
        step();

        // Read-port-only range error at exactly NUM_REGS.
        drive(0, 0, 0, 0, 24, 0);
        expect_next(K_RDB, '0, "read at NUM_REGS returns 0");
        expect_next(K_ERR, 32'd1, "bad read sets addr_err");
        step();

        // Reset in RUN zeroes outputs immediately.
        drive(1, 4, 32'h77, 0, 0, 0);
        step();
        drive(0, 0, 0, 4, 4, 0);
        expect_next(K_RDA, 32'h77, "r4 before reset");
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("rst rdDA", bus.rdDA, '0);
        check("rst rdDB", bus.rdDB, '0);
        check("rst ready", DATA_W'(bus.ready), '0);
        check("rst addr_err", DATA_W'(bus.addr_err), '0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        expect_sweep(edge_cnt, "post-reset ready");
        repeat (NUM_REGS) step();

        // Reset while the clear pointer is at 10 restarts the sweep.
        drive(0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        check("mid-sweep rst ready", DATA_W'(bus.ready), '0);
        check("mid-sweep rst rout", bus.rout, '0);
        step();
        rst_n = 1'b1;
        expect_sweep(edge_cnt, "restarted sweep ready");
        repeat (NUM_REGS) step();
        drive(0, 0, 0, 5, 23, 0);
        expect_next(K_RDA, '0, "r5 after restart");
        expect_next(K_RDB, '0, "r23 after restart");
        step();
        repeat (2) step();

        check("scoreboard drained", DATA_W'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
